// File: rtl/snake_tick_gen.sv
// Movement-tick generator: paces snake moves with a one-cycle tick and a mid-period
// half_tick, with a food-driven speed-up that saturates at MIN_PERIOD.
module snake_tick_gen #(
   parameter int unsigned CNT_W       = 28,
   parameter int unsigned BASE_PERIOD = 25_000_000,
   parameter int unsigned MIN_PERIOD  = 5_000_000,
   parameter int unsigned STEP        = 1_000_000,
   parameter int unsigned LVL_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             pause,
   input  logic             speed_up,
   input  logic             speed_clr,
   output logic             tick,
   output logic             half_tick,
   output logic [CNT_W-1:0] period,
   output logic [LVL_W-1:0] level,
   output logic             at_max
);

   localparam logic [CNT_W-1:0] BASE_X = CNT_W'(BASE_PERIOD);
   localparam logic [CNT_W-1:0] MIN_X  = CNT_W'(MIN_PERIOD);
   // STEP saturated to the widened range so an oversized step still clamps to MIN_PERIOD
   localparam logic [CNT_W:0]   STEP_X = ((64'(STEP) >> (CNT_W + 1)) != 64'd0) ? '1
                                         : (CNT_W + 1)'(STEP);

   generate
      if (MIN_PERIOD < 2) begin : g_chk_min
         $fatal(1, "snake_tick_gen: MIN_PERIOD must be >= 2");
      end
      if (BASE_PERIOD < MIN_PERIOD) begin : g_chk_base
         $fatal(1, "snake_tick_gen: BASE_PERIOD must be >= MIN_PERIOD");
      end
      if ((64'(BASE_PERIOD) >> CNT_W) != 64'd0) begin : g_chk_width
         $fatal(1, "snake_tick_gen: BASE_PERIOD must fit in CNT_W bits");
      end
      if (STEP < 1) begin : g_chk_step
         $fatal(1, "snake_tick_gen: STEP must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_STOP,
      ST_RUN,
      ST_PAUSE
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             tick_q, tick_d;
   logic             half_q, half_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] headroom;
   logic             last_phase;
   logic             mid_phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_STOP;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_STOP;
      end else begin
         case (state_q)
            ST_STOP:  state_d = pause ? ST_PAUSE : ST_RUN;
            ST_RUN:   if (pause)  state_d = ST_PAUSE;
            ST_PAUSE: if (!pause) state_d = ST_RUN;
            default:  state_d = ST_STOP;
         endcase
      end
   end

   // Phase actions follow the state being entered, so the edge that leaves STOP already counts.
   always_comb begin
      last_phase = (count_q >= (period_q - CNT_W'(1)));
      mid_phase  = (count_q == ((period_q >> 1) - CNT_W'(1)));
      count_d    = count_q;
      tick_d     = 1'b0;
      half_d     = 1'b0;
      case (state_d)
         ST_STOP: count_d = '0;
         ST_RUN: begin
            half_d = mid_phase;
            if (last_phase) begin
               count_d = '0;
               tick_d  = 1'b1;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         ST_PAUSE: count_d = count_q;
         default:  count_d = '0;
      endcase
   end

   always_comb begin
      headroom = period_q - MIN_X;
      period_d = period_q;
      level_d  = level_q;
      if (speed_clr) begin
         period_d = BASE_X;
         level_d  = '0;
      end else if (speed_up && (period_q > MIN_X)) begin
         if ({1'b0, headroom} <= STEP_X) begin
            period_d = MIN_X;
         end else begin
            period_d = period_q - STEP_X[CNT_W-1:0];
         end
         if (level_q != '1) begin
            level_d = level_q + LVL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         tick_q   <= 1'b0;
         half_q   <= 1'b0;
         period_q <= BASE_X;
         level_q  <= '0;
      end else begin
         count_q  <= count_d;
         tick_q   <= tick_d;
         half_q   <= half_d;
         period_q <= period_d;
         level_q  <= level_d;
      end
   end

   assign tick      = tick_q;
   assign half_tick = half_q;
   assign period    = period_q;
   assign level     = level_q;
   assign at_max    = (period_q == MIN_X);

endmodule

// File: tb/tb_snake_tick_gen.sv
// Bench for snake_tick_gen: directed scenarios, a per-cycle behavioural model,
// and literal tick/half_tick edge positions for each scenario.
module tb_snake_tick_gen;

   localparam int CW   = 8;
   localparam int BASE = 10;
   localparam int MINP = 4;
   localparam int STP  = 3;
   localparam int LW   = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          pause = 1'b0;
   logic          speed_up = 1'b0;
   logic          speed_clr = 1'b0;
   logic          tick;
   logic          half_tick;
   logic [CW-1:0] period;
   logic [LW-1:0] level;
   logic          at_max;

   snake_tick_gen #(
      .CNT_W(CW), .BASE_PERIOD(BASE), .MIN_PERIOD(MINP), .STEP(STP), .LVL_W(LW)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .pause(pause),
      .speed_up(speed_up), .speed_clr(speed_clr),
      .tick(tick), .half_tick(half_tick), .period(period),
      .level(level), .at_max(at_max)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: the phase advances on edges with enable=1 and pause=0, clears when disabled.
   int m_count, m_per, m_lvl;
   bit m_tick, m_half, m_valid = 1'b0;

   always @(posedge clk) begin
      int c, p, l;
      bit t, h;
      c = m_count; p = m_per; l = m_lvl; t = 1'b0; h = 1'b0;
      if (rst) begin
         c = 0; p = BASE; l = 0;
         m_valid <= 1'b1;
      end else begin
         if (!enable) begin
            c = 0;
         end else if (!pause) begin
            h = (m_count == m_per / 2 - 1);
            if (m_count + 1 >= m_per) begin
               c = 0; t = 1'b1;
            end else begin
               c = m_count + 1;
            end
         end
         if (speed_clr) begin
            p = BASE; l = 0;
         end else if (speed_up && m_per > MINP) begin
            p = (m_per - STP < MINP) ? MINP : m_per - STP;
            l = (m_lvl == (1 << LW) - 1) ? m_lvl : m_lvl + 1;
         end
      end
      m_count <= c; m_per <= p; m_lvl <= l; m_tick <= t; m_half <= h;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("tick", 32'(tick), 32'(m_tick));
         chk("half_tick", 32'(half_tick), 32'(m_half));
         chk("period", 32'(period), 32'(m_per));
         chk("level", 32'(level), 32'(m_lvl));
         chk("at_max", 32'(at_max), 32'(m_per == MINP));
      end
   end

   int edge_n = 0;
   int base_n = 0;
   int tick_q[$];
   int half_q[$];

   always @(posedge clk) edge_n <= edge_n + 1;

   always @(negedge clk) begin
      if (m_valid) begin
         if (tick === 1'b1)      tick_q.push_back(edge_n - base_n);
         if (half_tick === 1'b1) half_q.push_back(edge_n - base_n);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_seg();
      base_n = edge_n;
      tick_q.delete();
      half_q.delete();
   endtask

   task automatic chk_seq(input string nm, input bit use_half, input int n,
                          input int a, input int b, input int c);
      int got[$];
      int e;
      got = use_half ? half_q : tick_q;
      chk({nm, " count"}, 32'(got.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         e = (i == 0) ? a : (i == 1) ? b : c;
         chk({nm, " edge"}, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(e));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ep[3] = '{7, 4, 4};
      int el[3] = '{1, 2, 2};
      int em[3] = '{0, 1, 1};

      cyc(2);
      chk("reset tick", 32'(tick), 32'd0);
      chk("reset half", 32'(half_tick), 32'd0);
      chk("reset period", 32'(period), 32'd10);
      chk("reset level", 32'(level), 32'd0);
      chk("reset at_max", 32'(at_max), 32'd0);

      rst = 1'b0; enable = 1'b1;
      start_seg();
      cyc(31);
      chk_seq("startup tick", 1'b0, 3, 10, 20, 30);
      chk_seq("startup half", 1'b1, 3, 5, 15, 25);

      enable = 1'b0;
      cyc(1);
      chk("stop tick", 32'(tick), 32'd0);
      chk("stop period", 32'(period), 32'd10);

      for (int i = 0; i < 3; i++) begin
         speed_up = 1'b1;
         cyc(1);
         chk("speedup period", 32'(period), 32'(ep[i]));
         chk("speedup level", 32'(level), 32'(el[i]));
         chk("speedup at_max", 32'(at_max), 32'(em[i]));
      end
      speed_up = 1'b0;

      enable = 1'b1;
      start_seg();
      cyc(13);
      chk_seq("fast tick", 1'b0, 3, 4, 8, 12);
      chk_seq("fast half", 1'b1, 3, 2, 6, 10);

      enable = 1'b0;
      cyc(1);
      speed_clr = 1'b1; speed_up = 1'b1;
      cyc(1);
      speed_clr = 1'b0; speed_up = 1'b0;
      chk("clr period", 32'(period), 32'd10);
      chk("clr level", 32'(level), 32'd0);
      chk("clr at_max", 32'(at_max), 32'd0);

      enable = 1'b1;
      start_seg();
      cyc(16);
      pause = 1'b1;
      cyc(7);
      pause = 1'b0;
      cyc(5);
      chk_seq("pause tick", 1'b0, 2, 10, 27, 0);
      chk_seq("pause half", 1'b1, 2, 5, 15, 0);

      enable = 1'b0;
      cyc(1);
      enable = 1'b1;
      start_seg();
      cyc(8);
      speed_up = 1'b1;
      cyc(1);
      speed_up = 1'b0;
      cyc(16);
      chk_seq("late tick", 1'b0, 3, 10, 17, 24);
      chk_seq("late half", 1'b1, 3, 5, 13, 20);
      chk("late period", 32'(period), 32'd7);
      chk("late level", 32'(level), 32'd1);

      cyc(2);
      enable = 1'b0;
      cyc(1);
      chk("drop tick", 32'(tick), 32'd0);
      chk("drop half", 32'(half_tick), 32'd0);
      chk("drop period", 32'(period), 32'd7);

      enable = 1'b1;
      start_seg();
      cyc(8);
      chk_seq("restart tick", 1'b0, 1, 7, 0, 0);
      chk_seq("restart half", 1'b1, 1, 3, 0, 0);

      rst = 1'b1; speed_up = 1'b1;
      cyc(1);
      chk("rst tick", 32'(tick), 32'd0);
      chk("rst half", 32'(half_tick), 32'd0);
      chk("rst period", 32'(period), 32'd10);
      chk("rst level", 32'(level), 32'd0);
      chk("rst at_max", 32'(at_max), 32'd0);
      rst = 1'b0; speed_up = 1'b0; enable = 1'b0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/snake_tick_gen.md
# snake_tick_gen

Parametrised movement-tick generator for the snake game datapath. It produces a one-cycle `tick` that paces snake movement, plus a mid-period `half_tick` for animation and blink effects. The tick period shortens by a fixed step on each food-eaten event, saturating at a minimum period, and can be restored to the base period. Run/pause/stop control comes from the game FSM, and the current period and speed level are exported to the score/HUD logic.

## Interface
Parameters:
- `CNT_W`, 28: width of the period counter and `period` output.
- `BASE_PERIOD`, 25_000_000: initial and restored tick period, in clk cycles.
- `MIN_PERIOD`, 5_000_000: fastest allowed period, in clk cycles.
- `STEP`, 1_000_000: period decrement per `speed_up`.
- `LVL_W`, 4: width of the `level` output.

Ports:
- `clk`  in  1  system clock; one clock, all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `enable`  in  1  high = game running; low = stop and clear phase.
- `pause`  in  1  high = freeze phase; no ticks.
- `speed_up`  in  1  one-cycle pulse (food eaten); shorten period.
- `speed_clr`  in  1  one-cycle pulse; period := BASE_PERIOD, level := 0.
- `tick`  out  1  registered one-cycle movement pulse.
- `half_tick`  out  1  registered one-cycle pulse at the period midpoint.
- `period`  out  CNT_W  current period.
- `level`  out  LVL_W  number of effective speed-ups, saturating.
- `at_max`  out  1  high when `period == MIN_PERIOD`.

## Operation
- Elaboration checks (fatal on violation):
  - MIN_PERIOD ≥ 2.
  - BASE_PERIOD ≥ MIN_PERIOD.
  - BASE_PERIOD < 2^CNT_W.
  - STEP ≥ 1.
- FSM states: STOP, RUN, PAUSE.
  - Priority: `rst` > `enable`=0 > `pause`.
  - From any state, `enable`=0 → STOP.
  - STOP with `enable`=1 → RUN if `pause`=0, else PAUSE.
  - RUN with `pause`=1 → PAUSE.
  - PAUSE with `pause`=0 → RUN.
- Phase counter `count` (CNT_W bits):
  - STOP: `count` := 0.
  - PAUSE: `count` holds.
  - RUN, `count` ≥ `period`−1: `count` := 0 and `tick` := 1.
  - RUN, otherwise: `count` := `count`+1.
- `half_tick` := 1 on a RUN edge where `count == (period>>1)−1`. Otherwise `tick` and `half_tick` are 0, and both are 0 in STOP and PAUSE.
- Speed update, evaluated in every state including STOP and PAUSE:
  - `speed_clr` = 1: `period` := BASE_PERIOD, `level` := 0. `speed_clr` wins over a simultaneous `speed_up`.
  - Else, if `speed_up` = 1 and `period` > MIN_PERIOD:
    - `period` := max(`period`−STEP, MIN_PERIOD). The subtraction is computed in CNT_W+1 bits, so it never wraps.
    - `level` := `level`+1, saturating at 2^LVL_W−1.
  - `speed_up` with `period` == MIN_PERIOD has no effect.
- The terminal compare is `count` ≥ `period`−1, not equality. If a speed-up drops `period` below the current phase, the next RUN edge ticks and wraps. The counter never runs out to 2^CNT_W.
- `speed_clr` and `speed_up` do not modify `count`.
- `at_max` is combinational from the `period` register.

## Timing
- Reset values (on the first edge with `rst`=1):
  - State STOP, `count`=0.
  - `tick`=0, `half_tick`=0.
  - `period`=BASE_PERIOD, `level`=0, `at_max`=(BASE_PERIOD==MIN_PERIOD).
- Number RUN edges from 1, where the first edge that samples `enable`=1, `pause`=0 from STOP is edge 1. Then:
  - `tick` is high for the cycle after edge P, with P = `period`.
  - Subsequent ticks come exactly P cycles apart.
  - `half_tick` is high after edge floor(P/2).
- PAUSE stretches the tick gap by exactly the number of paused edges. The phase is preserved.
- A new `period` is visible one cycle after the `speed_up`/`speed_clr` edge and governs the very next compare.
- Dropping `enable` forces `tick` and `half_tick` to 0 on the same edge. Re-enabling restarts from phase 0.
- `rst` mid-run overrides all inputs, including a simultaneous `speed_up`.

## Test plan
Parameters: CNT_W=8, BASE=10, MIN=4, STEP=3, LVL_W=2.
- **Start-up:** `rst` 2 cycles, then `enable`=1 → `tick` after edges 10, 20, 30; `half_tick` after edges 5, 15, 25; `period`=10, `level`=0, `at_max`=0.
- **Speed-up sequence:** three `speed_up` pulses while STOPped → `period` 10→7→4→4; `level` 1, 2, 2; `at_max`=1 after the second pulse. In RUN, ticks then 4 cycles apart and `half_tick` 2 cycles after each tick.
- **Pause:** `pause`=1 for 7 cycles at `count`=6 (period 10) → no `tick`/`half_tick` during the pause; next `tick` 17 cycles after the previous one.
- **Late speed-up:** `speed_up` at `count`=8 with period 10 → `period`=7; `tick` on the next edge; following ticks 7 apart.
- **Simultaneous pulses:** `speed_clr` and `speed_up` on the same edge at period 4, level 2 → `period`=10, `level`=0, `at_max`=0.
- **Stop and reset:** `enable` drop mid-count → `count`=0, outputs 0, period kept. `rst` during RUN with `speed_up`=1 → all reset values, no tick.
